// File: rtl/bp_resolve_queue_if.sv
// rtl/bp_resolve_queue_if.sv - prediction/resolve/retire bundle for the branch resolve queue
// Purpose: groups every non-clock/reset signal of bp_resolve_queue.
//   master : predictor + execute + retire consumer side (drives pred_*, res_*, squash)
//   slave  : the queue itself (drives pred_ready/pred_tag, mispredict/redirect, train_*, count)
`ifndef XLEN
`define XLEN 32
`endif

interface bp_resolve_queue_if #(
  parameter int DEPTH = 8,
  parameter int XLEN  = `XLEN
);
  localparam int IDX_W = $clog2(DEPTH);

  // prediction push
  logic              pred_valid;
  logic [XLEN-1:0]   pred_pc;
  logic [XLEN-1:0]   pred_npc;
  logic              pred_taken;
  logic              pred_ready;
  logic [IDX_W-1:0]  pred_tag;
  // out-of-order resolve
  logic              res_valid;
  logic [IDX_W-1:0]  res_tag;
  logic              res_taken;
  logic [XLEN-1:0]   res_target;
  // flush
  logic              squash;
  // in-order retire
  logic              mispredict;
  logic [XLEN-1:0]   redirect_pc;
  logic              train_valid;
  logic [XLEN-1:0]   train_pc;
  logic              train_taken;
  logic [XLEN-1:0]   train_target;
  logic [IDX_W:0]    count;

  modport master (
    output pred_valid, pred_pc, pred_npc, pred_taken,
    input  pred_ready, pred_tag,
    output res_valid, res_tag, res_taken, res_target,
    output squash,
    input  mispredict, redirect_pc, train_valid, train_pc, train_taken, train_target, count
  );

  modport slave (
    input  pred_valid, pred_pc, pred_npc, pred_taken,
    output pred_ready, pred_tag,
    input  res_valid, res_tag, res_taken, res_target,
    input  squash,
    output mispredict, redirect_pc, train_valid, train_pc, train_taken, train_target, count
  );
endinterface

// File: rtl/bp_resolve_queue.sv
// rtl/bp_resolve_queue.sv - in-order retire queue closing the branch prediction loop
// Purpose: logs predictions in a circular queue (tag = slot index), accepts out-of-order
//   resolves, retires resolved entries in order, emits registered training writes and
//   mispredict redirects.
// Ports:
//   i_clock : rising-edge clock
//   i_reset : asynchronous active-low reset
//   s_q     : bp_resolve_queue_if.slave (push, resolve, squash, retire outputs, count)
`ifndef XLEN
`define XLEN 32
`endif

module bp_resolve_queue #(
  parameter int DEPTH = 8,
  parameter int XLEN  = `XLEN
) (
  input  logic                i_clock,
  input  logic                i_reset,
  bp_resolve_queue_if.slave   s_q
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] PTR_ONE = (IDX_W+1)'(1);

  // pointers carry a wrap bit above the slot index
  logic [IDX_W:0]   r_head, r_tail;
  logic [DEPTH-1:0] r_valid, r_resolved, r_ptaken, r_ataken;
  logic [XLEN-1:0]  r_pc      [DEPTH];
  logic [XLEN-1:0]  r_npc     [DEPTH];
  logic [XLEN-1:0]  r_atarget [DEPTH];

  logic             r_mispredict, r_train_valid, r_train_taken;
  logic [XLEN-1:0]  r_redirect_pc, r_train_pc, r_train_target;

  logic [IDX_W-1:0] w_head_idx, w_tail_idx;
  logic             w_full, w_push, w_pop, w_pop_mis, w_res_ok;
  logic [XLEN-1:0]  w_pop_target;

  assign w_head_idx = r_head[IDX_W-1:0];
  assign w_tail_idx = r_tail[IDX_W-1:0];
  assign w_full     = (w_head_idx == w_tail_idx) && (r_head[IDX_W] != r_tail[IDX_W]);

  assign w_push    = s_q.pred_valid && s_q.pred_ready;
  assign w_pop     = r_valid[w_head_idx] && r_resolved[w_head_idx];
  assign w_res_ok  = s_q.res_valid && r_valid[s_q.res_tag];

  assign w_pop_target = r_ataken[w_head_idx] ? r_atarget[w_head_idx]
                                             : r_pc[w_head_idx] + XLEN'(4);
  // direction wrong, or taken to the wrong target
  assign w_pop_mis = (r_ataken[w_head_idx] != r_ptaken[w_head_idx]) ||
                     (r_ataken[w_head_idx] && (r_atarget[w_head_idx] != r_npc[w_head_idx]));

  // no bypass: a full queue refuses a push even on a pop cycle
  assign s_q.pred_ready   = !w_full && !r_mispredict;
  assign s_q.pred_tag     = w_tail_idx;
  assign s_q.count        = r_tail - r_head;
  assign s_q.mispredict   = r_mispredict;
  assign s_q.redirect_pc  = r_redirect_pc;
  assign s_q.train_valid  = r_train_valid;
  assign s_q.train_pc     = r_train_pc;
  assign s_q.train_taken  = r_train_taken;
  assign s_q.train_target = r_train_target;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_valid        <= '0;
      r_resolved     <= '0;
      r_ptaken       <= '0;
      r_ataken       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]      <= '0;
        r_npc[i]     <= '0;
        r_atarget[i] <= '0;
      end
      r_mispredict   <= 1'b0;
      r_redirect_pc  <= '0;
      r_train_valid  <= 1'b0;
      r_train_pc     <= '0;
      r_train_taken  <= 1'b0;
      r_train_target <= '0;
    end else begin
      // retire outputs are pulses and read zero when idle
      r_mispredict   <= 1'b0;
      r_redirect_pc  <= '0;
      r_train_valid  <= 1'b0;
      r_train_pc     <= '0;
      r_train_taken  <= 1'b0;
      r_train_target <= '0;

      if (s_q.squash) begin
        r_head     <= '0;
        r_tail     <= '0;
        r_valid    <= '0;
        r_resolved <= '0;
      end else begin
        if (w_pop) begin
          r_train_valid  <= 1'b1;
          r_train_pc     <= r_pc[w_head_idx];
          r_train_taken  <= r_ataken[w_head_idx];
          r_train_target <= w_pop_target;
          if (w_pop_mis) begin
            r_mispredict  <= 1'b1;
            r_redirect_pc <= w_pop_target;
          end
        end

        if (w_pop && w_pop_mis) begin
          // everything younger is on the wrong path; resolve and push this edge are dropped
          r_valid    <= '0;
          r_resolved <= '0;
          r_head     <= r_head + PTR_ONE;
          r_tail     <= r_head + PTR_ONE;
        end else begin
          if (w_res_ok) begin
            r_resolved[s_q.res_tag] <= 1'b1;
            r_ataken[s_q.res_tag]   <= s_q.res_taken;
            r_atarget[s_q.res_tag]  <= s_q.res_target;
          end
          if (w_push) begin
            r_valid[w_tail_idx]    <= 1'b1;
            r_resolved[w_tail_idx] <= 1'b0;
            r_pc[w_tail_idx]       <= s_q.pred_pc;
            r_npc[w_tail_idx]      <= s_q.pred_npc;
            r_ptaken[w_tail_idx]   <= s_q.pred_taken;
            r_tail                 <= r_tail + PTR_ONE;
          end
          // placed last so a same-edge resolve of the retiring slot cannot revive it
          if (w_pop) begin
            r_valid[w_head_idx]    <= 1'b0;
            r_resolved[w_head_idx] <= 1'b0;
            r_head                 <= r_head + PTR_ONE;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_bp_resolve_queue.sv
// tb/tb_bp_resolve_queue.sv - scoreboard bench for bp_resolve_queue
`ifndef XLEN
`define XLEN 32
`endif

module tb_bp_resolve_queue;
  localparam int DEPTH = 8;
  localparam int XLEN  = `XLEN;
  localparam int IDX_W = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bp_resolve_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

  bp_resolve_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .s_q     (bus)
  );

  typedef struct {
    logic [XLEN-1:0] pc, npc, atarget;
    bit              ptaken, ataken, resolved;
    int              tag;
  } ent_t;

  typedef struct {
    bit              tv, taken, mis;
    logic [XLEN-1:0] pc, target, redirect;
  } exp_t;

  ent_t mq[$];
  exp_t expq[$];
  int   m_head = 0;
  bit   m_mis  = 0;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // reference model: a list of live predictions in age order, one step per clock edge
  task automatic model_step(input bit pv, input logic [XLEN-1:0] ppc, input logic [XLEN-1:0] pnpc,
                            input bit pt, input bit rv, input int rtag, input bit rt,
                            input logic [XLEN-1:0] rtg, input bit sq);
    exp_t e;
    ent_t h, n;
    bit ready, pop, mis;
    logic [XLEN-1:0] tgt;
    e = '{tv: 0, taken: 0, mis: 0, pc: '0, target: '0, redirect: '0};
    ready = (mq.size() < DEPTH) && !m_mis;
    pop   = (mq.size() > 0) && mq[0].resolved;
    mis   = 0;
    if (sq) begin
      mq.delete();
      m_head = 0;
    end else begin
      if (pop) begin
        h   = mq[0];
        tgt = h.ataken ? h.atarget : h.pc + 4;
        mis = (h.ataken != h.ptaken) || (h.ataken && h.atarget != h.npc);
        e.tv = 1; e.pc = h.pc; e.taken = h.ataken; e.target = tgt;
        if (mis) begin e.mis = 1; e.redirect = tgt; end
      end
      if (pop && mis) begin
        mq.delete();
        m_head = (m_head + 1) % DEPTH;
      end else begin
        if (rv) foreach (mq[i]) if (mq[i].tag == rtag) begin
          mq[i].resolved = 1; mq[i].ataken = rt; mq[i].atarget = rtg;
        end
        if (pv && ready) begin
          n.pc = ppc; n.npc = pnpc; n.ptaken = pt; n.ataken = 0; n.atarget = '0;
          n.resolved = 0; n.tag = (m_head + mq.size()) % DEPTH;
          mq.push_back(n);
        end
        if (pop) begin
          void'(mq.pop_front());
          m_head = (m_head + 1) % DEPTH;
        end
      end
    end
    m_mis = e.mis;
    expq.push_back(e);
  endtask

  task automatic cyc(input bit pv, input logic [XLEN-1:0] ppc, input logic [XLEN-1:0] pnpc,
                     input bit pt, input bit rv, input int rtag, input bit rt,
                     input logic [XLEN-1:0] rtg, input bit sq);
    @(negedge clk);
    bus.pred_valid = pv; bus.pred_pc = ppc; bus.pred_npc = pnpc; bus.pred_taken = pt;
    bus.res_valid = rv; bus.res_tag = IDX_W'(rtag); bus.res_taken = rt; bus.res_target = rtg;
    bus.squash = sq;
    #1;
    chk("pred_ready", 64'(bus.pred_ready), 64'((mq.size() < DEPTH) && !m_mis));
    chk("pred_tag", 64'(bus.pred_tag), 64'((m_head + mq.size()) % DEPTH));
    chk("count", 64'(bus.count), 64'(mq.size()));
    model_step(pv, ppc, pnpc, pt, rv, rtag, rt, rtg, sq);
  endtask

  task automatic push(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] npc, input bit pt);
    cyc(1, pc, npc, pt, 0, 0, 0, '0, 0);
  endtask
  task automatic res(input int tag, input bit t, input logic [XLEN-1:0] tgt);
    cyc(0, '0, '0, 0, 1, tag, t, tgt, 0);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, '0, '0, 0, 0, 0, 0, '0, 0);
  endtask
  task automatic sqz();
    cyc(0, '0, '0, 0, 0, 0, 0, '0, 1);
  endtask

  // monitor: one expected record per clock edge, compared just after the edge
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("train_valid", 64'(bus.train_valid), 64'(e.tv));
      chk("train_pc", 64'(bus.train_pc), 64'(e.pc));
      chk("train_taken", 64'(bus.train_taken), 64'(e.taken));
      chk("train_target", 64'(bus.train_target), 64'(e.target));
      chk("mispredict", 64'(bus.mispredict), 64'(e.mis));
      chk("redirect_pc", 64'(bus.redirect_pc), 64'(e.redirect));
    end else begin
      chk("idle_pulse", 64'({bus.train_valid, bus.mispredict}), 64'(0));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [XLEN-1:0] pc, npc, tgt;
    bit pv, pt, rv, rt, sq;
    int rtag, k;

    rst_n = 1'b0;
    bus.pred_valid = 0; bus.pred_pc = '0; bus.pred_npc = '0; bus.pred_taken = 0;
    bus.res_valid = 0; bus.res_tag = '0; bus.res_taken = 0; bus.res_target = '0; bus.squash = 0;
    #12;
    chk("rst_count", 64'(bus.count), 64'(0));
    chk("rst_tag", 64'(bus.pred_tag), 64'(0));
    chk("rst_train", 64'({bus.train_valid, bus.mispredict, bus.redirect_pc}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // 1: correct not-taken prediction trains at pc+4
    push(32'h100, 32'h104, 0);
    res(0, 0, '0);
    idle(3);
    // 2: taken to the wrong target redirects
    sqz();
    push(32'h200, 32'h240, 1);
    res(0, 1, 32'h280);
    idle(3);
    // 3: out-of-order resolves retire in tag order
    sqz();
    push(32'h300, 32'h304, 0);
    push(32'h310, 32'h314, 0);
    push(32'h320, 32'h324, 0);
    res(2, 0, '0);
    res(1, 0, '0);
    idle(1);
    res(0, 0, '0);
    idle(4);
    // 4: fill, refused push, pop, wrap to tag 0
    sqz();
    for (int i = 0; i < DEPTH; i++) push(32'h400 + 32'(i * 16), 32'h404 + 32'(i * 16), 0);
    push(32'h4f0, 32'h4f4, 0);
    res(0, 0, '0);
    push(32'h4f0, 32'h4f4, 0);
    push(32'h500, 32'h504, 0);
    idle(2);
    // 5: wrong direction on the head flushes younger entries
    sqz();
    for (int i = 0; i < 4; i++) push(32'h600 + 32'(i * 8), 32'h604 + 32'(i * 8), 0);
    res(0, 1, 32'h700);
    idle(1);
    res(2, 0, '0);
    idle(3);

    // randomized traffic
    sqz();
    for (int c = 0; c < 2500; c++) begin
      pv = ($urandom_range(0, 3) != 0);
      pc = {$urandom, 2'b00};
      pt = $urandom_range(0, 1) == 1;
      npc = pt ? {$urandom, 2'b00} : pc + 4;
      rv = ($urandom_range(0, 1) == 1);
      rtag = $urandom_range(0, DEPTH - 1);
      rt = $urandom_range(0, 1) == 1;
      tgt = {$urandom, 2'b00};
      if (rv && mq.size() > 0 && $urandom_range(0, 3) != 0) begin
        k = $urandom_range(0, mq.size() - 1);
        rtag = mq[k].tag;
        if ($urandom_range(0, 3) != 0) begin
          rt = mq[k].ptaken;
          tgt = mq[k].npc;
        end
      end
      sq = ($urandom_range(0, 63) == 0);
      cyc(pv, pc, npc, pt, rv, rtag, rt, tgt, sq);
    end
    idle(3);

    // 6: squash on the retire edge suppresses training
    sqz();
    push(32'h800, 32'h804, 0);
    push(32'h810, 32'h814, 0);
    res(0, 0, '0);
    cyc(0, '0, '0, 0, 0, 0, 0, '0, 1);
    idle(2);

    // async reset while a train pulse is on the outputs
    push(32'h900, 32'h904, 0);
    push(32'h910, 32'h914, 0);
    res(0, 0, '0);
    idle(1);
    @(posedge clk);
    #3;
    chk("pre_reset_train", 64'(bus.train_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("async_count", 64'(bus.count), 64'(0));
    chk("async_tag", 64'(bus.pred_tag), 64'(0));
    chk("async_train", 64'({bus.train_valid, bus.train_pc, bus.train_target}), 64'(0));
    chk("async_mis", 64'({bus.mispredict, bus.redirect_pc}), 64'(0));
    mq.delete();
    m_head = 0;
    m_mis = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_reset_ready", 64'(bus.pred_ready), 64'(1));
    idle(3);
    @(posedge clk);
    #4;
    chk("scoreboard_drained", 64'(expq.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
